// File: rtl/booth2_div_seq_pkg.sv
// Shared definitions for the sequential signed divider.
//   DIV_DATA_W  : default operand/result width
//   DIV_CNT_W   : default iteration counter width (2**DIV_CNT_W > DIV_DATA_W)
//   div_state_t : binary-encoded FSM states IDLE -> CALC -> FIX -> IDLE
package booth2_div_seq_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/booth2_div_addsub.sv
// W-bit ripple subtractor a - b, built from the multiplier's full-adder cell
// with b inverted and a carry-in of 1.
//   a, b : W-bit operands
//   diff : low W-1 bits of the difference
//   sign : msb of the difference (1 means the result is negative)
module booth2_div_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-2:0] diff,
    output logic         sign
);

    logic [W-1:0] carry;
    logic [W-2:0] sum_low;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < W - 1; gi++) begin : g_bit
            booth2_mul_3to2adder u_fa (
                .a    (a[gi]),
                .b    (~b[gi]),
                .cin  (carry[gi]),
                .sum  (sum_low[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // The top bit only needs its sum; its carry out would be discarded.
    assign diff = sum_low;
    assign sign = a[W-1] ^ ~b[W-1] ^ carry[W-1];

endmodule

// File: rtl/booth2_mul_3to2adder.sv
// Full-adder cell shared with the Booth-2 multiplier datapath.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module booth2_mul_3to2adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/booth2_div_seq.sv
// Sequential signed divider: radix-2 restoring division on magnitudes, one
// quotient bit per cycle, then a sign-fix cycle. Quotient truncates toward
// zero, remainder takes the sign of the dividend. Fixed latency: val_o is high
// DATA_W+2 cycles after the accept cycle.
//   clk, rst_n              : clock, asynchronous active-low reset
//   val_i / rdy_o           : request handshake (accept on val_i && rdy_o)
//   dividend_i, divisor_i   : signed operands sampled at accept
//   val_o                   : one-cycle result pulse
//   quotient_o, remainder_o : signed results, held until the next val_o
//   div0_o                  : divisor was zero (quotient -1, remainder = dividend)
module booth2_div_seq
    import booth2_div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              val_i,
    output logic              rdy_o,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              val_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              div0_o
);

    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    div_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] q_reg;
    logic [DATA_W-1:0] d_reg;
    // R never exceeds DATA_W bits between steps (R < D, or R <= |dividend|
    // when D is zero); only the shifted value R' needs the extra bit.
    logic [DATA_W-1:0] r_reg;
    logic              sign_q_reg;
    logic              sign_r_reg;
    logic              zero_reg;

    logic [DATA_W:0]   r_shift;
    logic [DATA_W-1:0] diff_low;
    logic              diff_neg;
    logic [DATA_W-1:0] dividend_mag;
    logic [DATA_W-1:0] divisor_mag;

    // ~x+1 kept at DATA_W bits: |MIN| becomes 2**(DATA_W-1) as unsigned.
    assign dividend_mag = dividend_i[DATA_W-1] ? (~dividend_i + ONE) : dividend_i;
    assign divisor_mag  = divisor_i[DATA_W-1]  ? (~divisor_i + ONE)  : divisor_i;

    assign r_shift = {r_reg, q_reg[DATA_W-1]};

    booth2_div_addsub #(
        .W (DATA_W + 1)
    ) u_sub (
        .a    (r_shift),
        .b    ({1'b0, d_reg}),
        .diff (diff_low),
        .sign (diff_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rdy_o      = 1'b0;
        case (state_reg)
            IDLE: begin
                rdy_o = 1'b1;
                if (val_i) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt_reg == '0) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            zero_reg    <= 1'b0;
            val_o       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div0_o      <= 1'b0;
        end else begin
            val_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (val_i) begin
                        q_reg      <= dividend_mag;
                        d_reg      <= divisor_mag;
                        r_reg      <= '0;
                        sign_q_reg <= dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1];
                        sign_r_reg <= dividend_i[DATA_W-1];
                        zero_reg   <= (divisor_i == '0);
                        cnt_reg    <= CNT_LAST;
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (!diff_neg) begin
                        r_reg <= diff_low;
                        q_reg <= {q_reg[DATA_W-2:0], 1'b1};
                    end else begin
                        r_reg <= r_shift[DATA_W-1:0];
                        q_reg <= {q_reg[DATA_W-2:0], 1'b0};
                    end
                end
                FIX: begin
                    // With D=0 every step subtracts nothing, so R ends up
                    // holding |dividend| and re-signing it restores the
                    // original dividend; only the quotient needs forcing.
                    if (zero_reg) begin
                        quotient_o <= '1;
                    end else begin
                        quotient_o <= sign_q_reg ? (~q_reg + ONE) : q_reg;
                    end
                    remainder_o <= sign_r_reg ? (~r_reg + ONE) : r_reg;
                    div0_o      <= zero_reg;
                    val_o       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth2_div_seq.sv
module tb_booth2_div_seq;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         val_i = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    logic         rdy_o;
    logic         val_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div0_o;

    booth2_div_seq #(
        .DATA_W (W),
        .CNT_W  (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .val_i       (val_i),
        .rdy_o       (rdy_o),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .val_o       (val_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .div0_o      (div0_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: plain signed arithmetic at 64 bits, so MIN / -1 is exact
    // and truncation-toward-zero / dividend-signed remainder come from the
    // language's own / and % operators.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, int acc);
        exp_t   e;
        longint sa, sd, qq, rr;
        e.a = a;
        e.b = b;
        e.acc = acc;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            qq = sa / sd;
            rr = sa % sd;
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rdy_timeout: rdy_o stayed 0, expected 1 within 200 cycles");
        end else begin
            val_i = 1'b1;
            dividend_i = a;
            divisor_i = b;
            sb.push_back(model(a, b, cyc));
            @(negedge clk);
            val_i = 1'b0;
            dividend_i = $urandom;
            divisor_i = $urandom;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t   e;
        longint sq, sr, sd, prod, ar, ad;
        if (rst_n && val_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_val_o: got q=%h r=%h, expected no result", quotient_o, remainder_o);
            end else begin
                e = sb.pop_front();
                $display("result %h / %h -> q=%h r=%h div0=%0b", e.a, e.b, quotient_o, remainder_o, div0_o);
                check("quotient", 64'(quotient_o), 64'(e.q));
                check("remainder", 64'(remainder_o), 64'(e.r));
                check("div0", 64'(div0_o), 64'(e.z));
                check("latency", 64'(cyc - e.acc), 64'(LAT));
                check("rdy_on_val", 64'(rdy_o), 64'd1);
                if (!e.z) begin
                    sq = longint'($signed(quotient_o));
                    sr = longint'($signed(remainder_o));
                    sd = longint'($signed(e.b));
                    prod = sq * sd + sr;
                    ar = (sr < 0) ? -sr : sr;
                    ad = (sd < 0) ? -sd : sd;
                    check("identity", 64'(prod[W-1:0]), 64'(e.a));
                    check("rem_bound", 64'(ar < ad), 64'd1);
                    check("rem_sign", 64'((sr == 0) || ((sr < 0) == e.a[W-1])), 64'd1);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        int           mode;

        // Reset state
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_rdy", 64'(rdy_o), 64'd1);
        check("reset_val", 64'(val_o), 64'd0);
        check("reset_q", 64'(quotient_o), 64'd0);
        check("reset_r", 64'(remainder_o), 64'd0);
        check("reset_div0", 64'(div0_o), 64'd0);
        rst_n = 1'b1;

        // Basic signs, issued back to back (each accept lands on the val_o cycle)
        issue(W'(100), W'(7));
        issue(W'(-100), W'(7));
        issue(W'(100), W'(-7));
        issue(W'(-100), W'(-7));

        // Overflow and divide by zero
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        issue(W'(5), W'(0));
        issue(W'(-9), W'(0));
        issue(32'h8000_0000, W'(0));

        // Request while busy must be ignored
        issue(W'(100), W'(7));
        repeat (5) @(negedge clk);
        val_i = 1'b1;
        dividend_i = W'(12345);
        divisor_i = W'(3);
        @(negedge clk);
        val_i = 1'b0;
        drain();

        // Reset in the middle of CALC
        @(negedge clk);
        while (!rdy_o) @(negedge clk);
        val_i = 1'b1;
        dividend_i = W'(1000);
        divisor_i = W'(7);
        @(negedge clk);
        val_i = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rdy", 64'(rdy_o), 64'd1);
        check("midrst_val", 64'(val_o), 64'd0);
        check("midrst_q", 64'(quotient_o), 64'd0);
        check("midrst_r", 64'(remainder_o), 64'd0);
        check("midrst_div0", 64'(div0_o), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(W'(1000), W'(10));

        // Randomised pairs, divisor never zero
        for (int i = 0; i < 1500; i++) begin
            mode = $urandom_range(0, 3);
            ra = $urandom;
            rb = $urandom;
            case (mode)
                1: begin
                    rb = W'($urandom_range(1, 255));
                    if ($urandom_range(0, 1) == 1) rb = ~rb + 1'b1;
                end
                2: ra = W'($urandom_range(0, 1000)) - W'(500);
                3: begin
                    case ($urandom_range(0, 3))
                        0: rb = W'(1);
                        1: rb = '1;
                        2: rb = 32'h8000_0000;
                        default: ra = 32'h8000_0000;
                    endcase
                end
                default: ;
            endcase
            if (rb == '0) rb = W'(1);
            issue(ra, rb);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
